axil_regtest_master: RTL and testbench
======================================

# axil_regtest_master

Synthesizable AXI4-Lite master that runs a sequential write-then-readback self-test over a parametrised bank of slave registers and reports pass/fail plus error statistics. It is the on-chip, parametrised successor to the four-register write/read/compare check used on the instruments peripheral. It generalises register count, width, base/stride and data pattern, and adds error counting and first-failure capture. It sits between a control/status source (software GPIO or a top-level FSM) and the AXI4-Lite slave port of the peripheral under test.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 or 64)
- NUM_REGS, 4, registers exercised (1..256)
- BASE_ADDR, 0, address of register 0
- ADDR_STRIDE, DATA_WIDTH/8, byte increment between registers
- START_VAL, 1, seed for incrementing patterns
- TIMEOUT_CYCLES, 1024, watchdog limit (only with macro)

- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; ignored unless idle
- mode  in  2  0 incr, 1 walking-one, 2 inverted incr, 3 = incr
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at completion
- pass  out  1  last test had zero errors; valid from done until next start
- err_count  out  16  saturating error count
- first_err_idx  out  8  index of first failing register
- timeout  out  1  watchdog fired (macro only)
- M_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite master channels: AWADDR, AWPROT=0, AWVALID/AWREADY, WDATA, WSTRB=all ones, WVALID/WREADY, BRESP, BVALID/BREADY, ARADDR, ARPROT=0, ARVALID/ARREADY, RDATA, RRESP, RVALID/RREADY

## Operation
- FSM: IDLE → WR_REQ → WR_RESP → (next idx or RD_REQ) → RD_DATA → (next idx or FIN) → IDLE.
- In IDLE, start latches mode, clears err_count, pass and first_err_idx (first_err_idx=0xFF = none), sets idx=0.
- Pattern(i) is combinational from idx and never stored: incr = START_VAL+i; walking = 1<<(i mod DATA_WIDTH); inverted = ~(START_VAL+i); arithmetic wraps at DATA_WIDTH.
- Address = BASE_ADDR + idx*ADDR_STRIDE, truncated to ADDR_WIDTH.
- WR_REQ: AWVALID and WVALID are raised together. Each drops independently on its own handshake. Move to WR_RESP once both are done.
- WR_RESP: BREADY=1. On B handshake, BRESP≠OKAY counts one error. idx increments; after idx NUM_REGS-1, idx resets to 0 and the FSM enters RD_REQ.
- RD_REQ: ARVALID until ARREADY. RD_DATA: RREADY=1. On R handshake, an error is counted if RDATA≠pattern(idx) or RRESP≠OKAY. This is one error per register, never two.
- Errors: err_count saturates at 0xFFFF. first_err_idx captures idx on the first error only; write-phase errors also capture it.
- FIN: pass = (err_count==0); done pulses; return to IDLE.

## Timing
- Reset values: all VALID/READY outputs 0, busy 0, done 0, pass 0, err_count 0, first_err_idx 0xFF, timeout 0, FSM IDLE.
- start in cycle N → busy=1 and AWVALID=WVALID=1 in cycle N+1.
- With an always-ready slave, zero wait: 2 cycles per write and 2 cycles per read. done occurs 4·NUM_REGS+1 cycles after start.
- VALID, once raised, holds with stable ADDR/DATA until handshake (AXI rule).
- BREADY and RREADY are asserted only in their response states.
- start while busy: ignored, no effect.
- Async reset mid-transaction: all outputs return to reset values immediately. An outstanding slave response after reset is not expected and is not tracked.
- done and busy=0 occur in the same cycle.

## Configuration
- AXIL_REGTEST_TIMEOUT_EN defined: a per-transaction watchdog counts cycles in any *_REQ/*_RESP/*_DATA state. On reaching TIMEOUT_CYCLES it sets timeout=1, counts one error, drops all VALIDs, and jumps to FIN (pass=0). timeout clears on next start.
- Undefined: no counter, timeout port tied 0, and the FSM waits indefinitely.

## Structure
- Package axil_regtest_pkg holds: the state enum, mode enum, RESP_OKAY constant, and the pattern function.
- One sub-module, axil_regtest_pattern: a combinational pattern generator (idx, mode → data), reused by future multi-channel variants.

## Test plan
- Always-ready memory-model slave, NUM_REGS=4, mode 0, START_VAL 1 → writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads match; pass=1, err_count=0, first_err_idx=0xFF, done 17 cycles after start.
- Mode 1, NUM_REGS=8, DATA_WIDTH=32 → data 0x1,0x2,…,0x80; pass=1.
- Slave corrupts reg 2 readback (bit 0 flipped) → err_count=1, first_err_idx=2, pass=0.
- Random AWREADY/WREADY skew (W accepted 3 cycles before AW) and random R/B stalls → single write per register, pass=1, VALID/data stable while stalled.
- Slave returns SLVERR on write to reg 1 and on read of reg 1 → err_count=2, first_err_idx=1; start pulsed while busy is ignored.
- With AXIL_REGTEST_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts ARREADY → timeout=1 within 16 cycles of ARVALID, done pulses, pass=0. Also assert ARESETN low mid-write → all VALIDs low the same cycle, busy=0.

Source files
------------

// File: rtl/axil_regtest_pkg.sv
// Shared types and helpers for the AXI4-Lite register self-test master.
// The state enum, mode enum, OKAY response code and the data-pattern
// function live here so the pattern generator and any future multi-channel
// variant derive identical data.
package axil_regtest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_INCR     = 2'd0,
        MODE_WALK     = 2'd1,
        MODE_INV      = 2'd2,
        MODE_INCR_ALT = 2'd3
    } mode_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Full 64-bit pattern; callers truncate to their data width. Truncation
    // preserves wrap-around because only the low bits of the sum matter.
    function automatic logic [63:0] pattern_calc(input logic [7:0]  idx,
                                                 input mode_e       mode,
                                                 input logic [63:0] start_val,
                                                 input int          data_width);
        logic [63:0] incr;
        incr = start_val + 64'(idx);
        case (mode)
            MODE_WALK: return 64'd1 << (int'(idx) % data_width);
            MODE_INV:  return ~incr;
            default:   return incr;
        endcase
    endfunction

endpackage

// File: rtl/axil_regtest_pattern.sv
// Combinational test-pattern generator: register index + mode -> data word.
// Kept as its own block so several test channels can share one definition.
module axil_regtest_pattern
    import axil_regtest_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] START_VAL  = 1
) (
    input  logic [7:0]            i_idx,
    input  mode_e                 i_mode,
    output logic [DATA_WIDTH-1:0] o_data
);

    assign o_data = DATA_WIDTH'(pattern_calc(i_idx, i_mode, 64'(START_VAL), DATA_WIDTH));

endmodule

// File: rtl/axil_regtest_master.sv
// AXI4-Lite master that writes a pattern to NUM_REGS slave registers, reads
// them back and reports pass/fail, a saturating error count and the index of
// the first failing register.
// Optional per-transaction watchdog: define AXIL_REGTEST_TIMEOUT_EN.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_WR_REQ  | AW and W valid, each dropped on its own handshake
// ST_WR_RESP | BREADY high, waiting for write response
// ST_RD_REQ  | ARVALID high until ARREADY
// ST_RD_DATA | RREADY high, compare RDATA/RRESP against the pattern
// ST_FIN     | done pulse, pass valid, back to idle
module axil_regtest_master
    import axil_regtest_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    NUM_REGS       = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    ADDR_STRIDE    = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] START_VAL      = 1,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    input  logic [1:0]              mode,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count,
    output logic [7:0]              first_err_idx,
    output logic                    timeout,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam logic [7:0] IDX_LAST = 8'(NUM_REGS - 1);

    // Unsupported parameter sets are rejected at elaboration.
    generate
        if (NUM_REGS < 1 || NUM_REGS > 256 || TIMEOUT_CYCLES < 1 ||
            (DATA_WIDTH != 32 && DATA_WIDTH != 64)) begin : g_param_check
            $error("axil_regtest_master: unsupported parameter set");
        end
    endgenerate

    state_e                  r_state;
    state_e                  w_next;
    mode_e                   r_mode;
    logic [7:0]              r_idx;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [15:0]             r_err_count;
    logic [7:0]              r_first_err_idx;
    logic                    r_pass_vld;
    logic                    w_err;
    logic                    w_idx_last;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_step;
    logic                    w_start;
    logic                    w_wdog_fire;
    logic [DATA_WIDTH-1:0]   w_pattern;
    logic [ADDR_WIDTH-1:0]   w_addr;

    axil_regtest_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .START_VAL  (START_VAL)
    ) u_pattern (
        .i_idx  (r_idx),
        .i_mode (r_mode),
        .o_data (w_pattern)
    );

    assign w_addr     = BASE_ADDR + ADDR_WIDTH'(r_idx) * ADDR_WIDTH'(ADDR_STRIDE);
    assign w_aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs     = M_AXI_WVALID && M_AXI_WREADY;
    assign w_idx_last = (r_idx == IDX_LAST);
    assign w_start    = (r_state == ST_IDLE) && start;
    assign w_step     = ((r_state == ST_WR_RESP) && M_AXI_BVALID) ||
                        ((r_state == ST_RD_DATA) && M_AXI_RVALID);

`ifdef AXIL_REGTEST_TIMEOUT_EN
    localparam int                WDW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0]    WDOG_RELOAD = WDW'(TIMEOUT_CYCLES - 1);

    logic [WDW-1:0] r_wdog;
    logic           r_timeout;
    logic           w_in_txn;

    assign w_in_txn    = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                         (r_state == ST_RD_REQ) || (r_state == ST_RD_DATA);
    assign w_wdog_fire = w_in_txn && (r_wdog == '0);
    assign timeout     = r_timeout;

    // Down-counting watchdog, reloaded on every state change so each
    // transaction phase gets the full budget.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wdog    <= WDOG_RELOAD;
            r_timeout <= 1'b0;
        end else begin
            if (w_start)
                r_timeout <= 1'b0;
            else if (w_wdog_fire)
                r_timeout <= 1'b1;
            if (!w_in_txn || (w_next != r_state))
                r_wdog <= WDOG_RELOAD;
            else
                r_wdog <= r_wdog - WDW'(1);
        end
    end
`else
    assign w_wdog_fire = 1'b0;
    assign timeout     = 1'b0;
`endif

    // Next-state and per-cycle error detection.
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_WR_REQ;
            ST_WR_REQ:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = ST_WR_RESP;
            ST_WR_RESP: if (M_AXI_BVALID) begin
                            w_err  = (M_AXI_BRESP != RESP_OKAY);
                            w_next = w_idx_last ? ST_RD_REQ : ST_WR_REQ;
                        end
            ST_RD_REQ:  if (M_AXI_ARREADY) w_next = ST_RD_DATA;
            ST_RD_DATA: if (M_AXI_RVALID) begin
                            w_err  = (M_AXI_RDATA != w_pattern) || (M_AXI_RRESP != RESP_OKAY);
                            w_next = w_idx_last ? ST_FIN : ST_RD_REQ;
                        end
            ST_FIN:     w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        if (w_wdog_fire) begin
            w_next = ST_FIN;
            w_err  = 1'b1;
        end
    end

    // State register, index, per-channel write handshake flags and statistics.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state         <= ST_IDLE;
            r_mode          <= MODE_INCR;
            r_idx           <= '0;
            r_aw_done       <= 1'b0;
            r_w_done        <= 1'b0;
            r_err_count     <= '0;
            r_first_err_idx <= 8'hFF;
            r_pass_vld      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_mode          <= mode_e'(mode);
                r_idx           <= '0;
                r_aw_done       <= 1'b0;
                r_w_done        <= 1'b0;
                r_err_count     <= '0;
                r_first_err_idx <= 8'hFF;
                r_pass_vld      <= 1'b0;
            end else begin
                if (r_state == ST_WR_REQ) begin
                    if (w_next != ST_WR_REQ) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) r_aw_done <= 1'b1;
                        if (w_w_hs)  r_w_done  <= 1'b1;
                    end
                end
                if (w_step)
                    r_idx <= w_idx_last ? 8'd0 : r_idx + 8'd1;
                if (w_err) begin
                    if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                    if (r_err_count == 16'd0)    r_first_err_idx <= r_idx;
                end
                if (r_state == ST_FIN)
                    r_pass_vld <= 1'b1;
            end
        end
    end

    assign busy          = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign done          = (r_state == ST_FIN);
    assign pass          = (r_pass_vld || done) && (r_err_count == 16'd0);
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;

    assign M_AXI_AWADDR  = w_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (r_state == ST_WR_REQ) && !r_aw_done;
    assign M_AXI_WDATA   = w_pattern;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (r_state == ST_WR_REQ) && !r_w_done;
    assign M_AXI_BREADY  = (r_state == ST_WR_RESP);
    assign M_AXI_ARADDR  = w_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (r_state == ST_RD_REQ);
    assign M_AXI_RREADY  = (r_state == ST_RD_DATA);

endmodule

// File: tb/tb_axil_regtest_master.sv
// Bench for axil_regtest_master: memory-model AXI4-Lite slave with
// per-channel latency knobs, read corruption and SLVERR injection.
module tb_axil_regtest_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode_in;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [7:0]  first_err_idx;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_err    = 0;

    // slave knobs
    int   aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
    int   corrupt_idx = -1, slverr_idx = -1;
    logic ar_never = 1'b0;
    logic sl_clr = 1'b0;

    always #5 clk = ~clk;

    axil_regtest_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .BASE_ADDR(32'h0),
        .ADDR_STRIDE(4), .START_VAL(32'd1), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .ACLK(clk), .ARESETN(rst_n), .start(start), .mode(mode_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .timeout(timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    // ---------------- slave model ----------------
    logic [31:0] mem    [0:15];
    int          wr_cnt [0:15];
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        have_aw, have_w, b_pend, r_pend;
    logic [31:0] aw_a, w_d, wc_addr, wc_data;
    logic [3:0]  b_i, r_i;

    assign awready = awvalid && (aw_cnt >= aw_lat);
    assign wready  = wvalid && (w_cnt >= w_lat);
    assign arready = arvalid && !ar_never && (ar_cnt >= ar_lat);
    assign bvalid  = b_pend && (b_cnt == 0);
    assign bresp   = (int'(b_i) == slverr_idx) ? 2'b10 : 2'b00;
    assign rvalid  = r_pend && (r_cnt == 0);
    assign rdata   = mem[r_i] ^ ((int'(r_i) == corrupt_idx) ? 32'h1 : 32'h0);
    assign rresp   = (int'(r_i) == slverr_idx) ? 2'b10 : 2'b00;
    assign wc_addr = have_aw ? aw_a : awaddr;
    assign wc_data = have_w ? w_d : wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_aw <= 1'b0; have_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            b_i <= '0; r_i <= '0;
        end else begin
            if (sl_clr)
                for (int i = 0; i < 16; i++) begin mem[i] <= '0; wr_cnt[i] <= 0; end
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (b_pend && b_cnt != 0) b_cnt <= b_cnt - 1;
            if (bvalid && bready) b_pend <= 1'b0;
            if ((have_aw || (awvalid && awready)) && (have_w || (wvalid && wready))) begin
                mem[wc_addr[5:2]]    <= wc_data;
                wr_cnt[wc_addr[5:2]] <= wr_cnt[wc_addr[5:2]] + 1;
                b_pend <= 1'b1; b_cnt <= b_lat; b_i <= wc_addr[5:2];
                have_aw <= 1'b0; have_w <= 1'b0;
            end else begin
                if (awvalid && awready) begin have_aw <= 1'b1; aw_a <= awaddr; end
                if (wvalid && wready)   begin have_w  <= 1'b1; w_d  <= wdata;  end
            end
            if (r_pend && r_cnt != 0) r_cnt <= r_cnt - 1;
            if (rvalid && rready) r_pend <= 1'b0;
            if (arvalid && arready) begin r_pend <= 1'b1; r_cnt <= r_lat; r_i <= araddr[5:2]; end
        end
    end

    // ---------------- VALID/payload stability monitor ----------------
    logic        p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
        end else begin
            if (p_aw) begin
                n_checks++;
                if (!(awvalid && awaddr == p_awaddr)) begin
                    n_err++; $display("FAIL aw_stable: awvalid=%0b awaddr=%0h required 1/%0h", awvalid, awaddr, p_awaddr);
                end
            end
            if (p_w) begin
                n_checks++;
                if (!(wvalid && wdata == p_wdata)) begin
                    n_err++; $display("FAIL w_stable: wvalid=%0b wdata=%0h required 1/%0h", wvalid, wdata, p_wdata);
                end
            end
            if (p_ar) begin
                n_checks++;
                if (!(arvalid && araddr == p_araddr)) begin
                    n_err++; $display("FAIL ar_stable: arvalid=%0b araddr=%0h required 1/%0h", arvalid, araddr, p_araddr);
                end
            end
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w  = wvalid && !wready;   p_wdata  = wdata;
            p_ar = arvalid && !arready; p_araddr = araddr;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_pat(input int m, input int i);
        case (m)
            1:       return 32'h1 << i;
            2:       return ~(32'(1 + i));
            default: return 32'(1 + i);
        endcase
    endfunction

    typedef struct {
        int mode; int corrupt; int slverr;
        int aw_l; int w_l; int ar_l; int b_l; int r_l;
        bit start_mid; bit exp_pass; int exp_err; int exp_first; int exp_cycles;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v, input string tag);
        int   cyc;
        logic got;
        aw_lat = v.aw_l; w_lat = v.w_l; ar_lat = v.ar_l; b_lat = v.b_l; r_lat = v.r_l;
        corrupt_idx = v.corrupt; slverr_idx = v.slverr;
        sl_clr = 1'b1;
        @(posedge clk); #1;
        sl_clr  = 1'b0;
        start   = 1'b1;
        mode_in = 2'(v.mode);
        @(posedge clk); #1;
        start   = 1'b0;
        mode_in = 2'(v.mode ^ 1);
        chk({tag, ".busy_n1"},    32'(busy), 1);
        chk({tag, ".awwvalid_n1"}, 32'(awvalid && wvalid), 1);
        chk({tag, ".timeout_clr"}, 32'(timeout), 0);
        chk({tag, ".wstrb"},      32'(wstrb), 32'hF);
        cyc = 1; got = done;
        while (!got && cyc < 400) begin
            if (v.start_mid && cyc == 6) begin start = 1'b1; mode_in = 2'd2; end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++; got = done;
        end
        chk({tag, ".done_seen"}, 32'(got), 1);
        if (v.exp_cycles != 0) chk({tag, ".latency"}, 32'(cyc), 32'(v.exp_cycles));
        chk({tag, ".busy_at_done"}, 32'(busy), 0);
        chk({tag, ".pass"},       32'(pass), 32'(v.exp_pass));
        chk({tag, ".err_count"},  32'(err_count), 32'(v.exp_err));
        chk({tag, ".first_err"},  32'(first_err_idx), 32'(v.exp_first));
        @(posedge clk); #1;
        chk({tag, ".done_1cyc"},  32'(done), 0);
        chk({tag, ".pass_hold"},  32'(pass), 32'(v.exp_pass));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.mem%0d", tag, i),   mem[i], exp_pat(v.mode, i));
            chk($sformatf("%s.wrcnt%0d", tag, i), 32'(wr_cnt[i]), 1);
        end
    endtask

    initial begin
        //           mode cor  slv  aw w ar b r  mid pass err first cycles
        vecs[0] = '{0, -1, -1, 0, 0, 0, 0, 0, 0, 1, 0, 8'hFF, 33};
        vecs[1] = '{1, -1, -1, 0, 0, 0, 0, 0, 0, 1, 0, 8'hFF, 33};
        vecs[2] = '{2, -1, -1, 0, 0, 0, 0, 0, 0, 1, 0, 8'hFF, 33};
        vecs[3] = '{3, -1, -1, 0, 0, 0, 0, 0, 0, 1, 0, 8'hFF, 33};
        vecs[4] = '{0,  2, -1, 0, 0, 0, 0, 0, 0, 0, 1, 2,     33};
        vecs[5] = '{0, -1, -1, 3, 0, 2, 2, 1, 0, 1, 0, 8'hFF, 0};
        vecs[6] = '{1, -1,  1, 0, 0, 0, 0, 0, 1, 0, 2, 1,     33};
        vecs[7] = '{2,  7,  7, 0, 0, 0, 0, 0, 0, 0, 2, 7,     33};
        vecs[8] = '{1,  0,  5, 0, 0, 0, 0, 0, 0, 0, 3, 5,     33};

        rst_n = 1'b0; start = 1'b0; mode_in = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.pass", 32'(pass), 0);
        chk("rst.err_count", 32'(err_count), 0);
        chk("rst.first_err", 32'(first_err_idx), 32'hFF);
        chk("rst.timeout", 32'(timeout), 0);
        chk("rst.valids", 32'({awvalid, wvalid, arvalid}), 0);
        chk("rst.readys", 32'({bready, rready}), 0);

        for (int k = 0; k < 9; k++)
            run_vec(vecs[k], $sformatf("v%0d", k));

        // asynchronous reset while a write is stalled on AWREADY
        aw_lat = 3; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0;
        corrupt_idx = -1; slverr_idx = -1;
        start = 1'b1; mode_in = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.aw_pending", 32'(awvalid), 1);
        chk("rstmid.busy_pre", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.valids", 32'({awvalid, wvalid, arvalid}), 0);
        chk("rstmid.readys", 32'({bready, rready}), 0);
        chk("rstmid.busy", 32'(busy), 0);
        chk("rstmid.done", 32'(done), 0);
        chk("rstmid.first_err", 32'(first_err_idx), 32'hFF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef AXIL_REGTEST_TIMEOUT_EN
        begin
            int cyc, arv_cyc;
            aw_lat = 0; ar_never = 1'b1;
            start = 1'b1; mode_in = 2'd0;
            @(posedge clk); #1;
            start = 1'b0;
            cyc = 1; arv_cyc = -1;
            while (!done && cyc < 400) begin
                if (arvalid && arv_cyc < 0) arv_cyc = cyc;
                @(posedge clk); #1;
                cyc++;
            end
            chk("to.done_seen", 32'(done), 1);
            chk("to.timeout", 32'(timeout), 1);
            chk("to.pass", 32'(pass), 0);
            chk("to.err_count", 32'(err_count), 1);
            chk("to.first_err", 32'(first_err_idx), 0);
            chk("to.arvalid_dropped", 32'(arvalid), 0);
            chk("to.within_16", 32'(arv_cyc > 0 && (cyc - arv_cyc) <= 16), 1);
            ar_never = 1'b0;
            @(posedge clk); #1;
        end
`endif

        run_vec(vecs[0], "rerun");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
